// File: rtl/rf_queue_ctrl.sv
// FIFO controller driving an 8x3 write/read/down-shift register file; entry 0 is always the head.
// Optional sticky misuse flag Err is built only when RF_QUEUE_ERR_EN is defined.
module rf_queue_ctrl #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 3,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              PushValid,
    input  logic [DATA_W-1:0] PushData,
    output logic              PushReady,
    input  logic              PopReq,
    output logic              PopAck,
    input  logic              Flush,
    output logic [DATA_W-1:0] WriteData,
    output logic [ADDR_W-1:0] WriteAddr,
    output logic              WRF,
    output logic              DownShift,
    output logic [ADDR_W-1:0] ReadAddr,
    output logic [ADDR_W:0]   Count,
    output logic              Empty,
    output logic              Full,
    output logic              Busy,
    output logic              Err
);

    typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [ADDR_W:0] ZERO_C  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic                wrf_q, wrf_d;
    logic                ds_q, ds_d;
    logic                pop_ack_q, pop_ack_d;
    logic                busy_q, busy_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                push_acc_s, pop_acc_s, flush_acc_s;

    // Flush outranks push and pop; nothing is accepted while the flush drains.
    assign PushReady   = (state_q == IDLE) && !full_q && !Flush;
    assign push_acc_s  = PushValid && PushReady;
    assign pop_acc_s   = (state_q == IDLE) && PopReq && !empty_q && !Flush;
    assign flush_acc_s = (state_q == IDLE) && Flush;

    // State and command registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            count_q   <= ZERO_C;
            wdata_q   <= {DATA_W{1'b0}};
            waddr_q   <= {ADDR_W{1'b0}};
            wrf_q     <= 1'b0;
            ds_q      <= 1'b0;
            pop_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wdata_q   <= wdata_d;
            waddr_q   <= waddr_d;
            wrf_q     <= wrf_d;
            ds_q      <= ds_d;
            pop_ack_q <= pop_ack_d;
            busy_q    <= busy_d;
            empty_q   <= empty_d;
            full_q    <= full_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_acc_s && (count_q != ZERO_C)) state_d = FLUSH;
                else                                    state_d = IDLE;
            end
            FLUSH: begin
                if (count_q == ONE_C) state_d = IDLE;
                else                  state_d = FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    // Register-file commands and occupancy; a simultaneous push/pop writes at Count then shifts.
    always_comb begin
        count_d   = count_q;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        wrf_d     = 1'b0;
        ds_d      = 1'b0;
        pop_ack_d = 1'b0;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_acc_s) begin
                    busy_d = 1'b1;
                end else begin
                    if (push_acc_s) begin
                        wrf_d   = 1'b1;
                        waddr_d = count_q[ADDR_W-1:0];
                        wdata_d = PushData;
                    end else begin
                        wrf_d = 1'b0;
                    end
                    if (pop_acc_s) begin
                        ds_d      = 1'b1;
                        pop_ack_d = 1'b1;
                    end else begin
                        ds_d = 1'b0;
                    end
                    case ({push_acc_s, pop_acc_s})
                        2'b10:   count_d = count_q + ONE_C;
                        2'b01:   count_d = count_q - ONE_C;
                        default: count_d = count_q;
                    endcase
                end
            end
            FLUSH: begin
                ds_d    = 1'b1;
                count_d = count_q - ONE_C;
                busy_d  = (count_q != ONE_C);
            end
            default: begin
                count_d = ZERO_C;
            end
        endcase
        empty_d = (count_d == ZERO_C);
        full_d  = (count_d == DEPTH_C);
    end

`ifdef RF_QUEUE_ERR_EN
    logic err_q, err_d;

    // Sticky misuse flag, cleared by an accepted flush
    always_comb begin
        err_d = err_q;
        if (flush_acc_s) begin
            err_d = 1'b0;
        end else if ((state_q == IDLE) &&
                     ((PushValid && full_q) || (PopReq && empty_q && !Flush))) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Misuse flag register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign WriteData = wdata_q;
    assign WriteAddr = waddr_q;
    assign WRF       = wrf_q;
    assign DownShift = ds_q;
    assign PopAck    = pop_ack_q;
    assign ReadAddr  = {ADDR_W{1'b0}};
    assign Count     = count_q;
    assign Empty     = empty_q;
    assign Full      = full_q;
    assign Busy      = busy_q;

endmodule

// File: doc/rf_queue_ctrl.md
Name: rf_queue_ctrl

Overview:
- FIFO controller that sits directly upstream of the 8-entry x 3-bit register file (write/read/down-shift type).
- Turns a producer push handshake and a consumer pop request into that file's WriteData/WriteAddr/WRF/DownShift commands.
- Entry 0 of the file is always the queue head; ReadAddr is held at 0 so the file's ReadData presents the head.
- Tracks occupancy and runs a multi-cycle flush, because the file has no synchronous clear.

Parameters:
- DEPTH, 8, number of register-file entries managed.
- DATA_W, 3, token width; equals the register-file data width.
- ADDR_W, 3, register-file address width; DEPTH = 2**ADDR_W.

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  reset, asynchronous, active-high.
- PushValid  input  1  producer has a token.
- PushData  input  DATA_W  token value.
- PushReady  output  1  controller can accept a token.
- PopReq  input  1  consumer requests removal of the head.
- PopAck  output  1  one-cycle pulse: pop accepted.
- Flush  input  1  empty the queue.
- WriteData  output  DATA_W  to register file.
- WriteAddr  output  ADDR_W  to register file.
- WRF  output  1  to register file, write strobe.
- DownShift  output  1  to register file, shift strobe.
- ReadAddr  output  ADDR_W  to register file; constant 0.
- Count  output  ADDR_W+1  occupancy, 0..DEPTH.
- Empty  output  1  Count==0.
- Full  output  1  Count==DEPTH.
- Busy  output  1  flush in progress.
- Err  output  1  sticky misuse flag (see Optional Feature).

Behaviour:
- Reset values:
  - WriteData=0, WriteAddr=0, WRF=0, DownShift=0, PopAck=0, ReadAddr=0.
  - Count=0, Empty=1, Full=0, Busy=0, Err=0, state=IDLE.
  - PushReady=1 once Rst is low.
  - The register file is reset by the same Rst.
- All outputs are registered except PushReady.
  - PushReady = (state==IDLE) && !Full && !Flush.
- FSM has two states, IDLE and FLUSH.
- Push (IDLE): on an edge with PushValid && PushReady:
  - WRF<=1, WriteAddr<=Count, WriteData<=PushData, Count<=Count+1.
  - WRF is high for exactly one cycle; the register file commits the write on the following edge.
- Pop (IDLE): on an edge with PopReq && !Empty && !Flush:
  - DownShift<=1 and PopAck<=1 for one cycle; Count<=Count-1.
- Simultaneous push and pop (IDLE, 0<Count<DEPTH):
  - Both commands are issued in the same cycle with WriteAddr=Count(old).
  - The file writes first, then shifts, so the token lands at Count-1.
  - Count is unchanged.
  - When Full, only the pop is accepted (PushReady=0).
- Back-to-back operations use the updated Count, giving contiguous addresses.
  - Example: three pushes from empty give WriteAddr 0,1,2.
- Pop while Empty: ignored; no DownShift, no PopAck.
- Flush:
  - Flush sampled high in IDLE has priority over push and pop in that cycle; neither is accepted.
  - If Count==0: Busy pulses for one cycle and the FSM stays in IDLE.
  - Otherwise: state<=FLUSH, Busy<=1.
  - In FLUSH, DownShift is asserted for exactly Count(at entry) consecutive cycles; Count decrements each cycle.
  - When Count reaches 0: state<=IDLE, Busy<=0.
  - In FLUSH: PushReady=0; PopReq and Flush are ignored; PopAck stays 0.
- Rst asserted mid-flush or mid-operation: immediate return to reset values; any strobe in flight is dropped.
- Count arithmetic is ADDR_W+1 bits and never wraps: push is blocked at DEPTH, pop is blocked at 0.

Optional Feature:
- Macro: RF_QUEUE_ERR_EN.
- Defined:
  - Err is set on any edge with (PushValid && Full && state==IDLE) or (PopReq && Empty && state==IDLE && !Flush).
  - Err holds until Rst, or until a Flush is accepted (cleared on that edge).
- Undefined: Err is tied to 0 and no error logic is built.

Test Plan:
- Reset then push 2,5,7 on three consecutive cycles -> WRF pulses with WriteAddr 0,1,2; Count=3; file head (ReadAddr 0) reads 2.
- Count=3, single pop -> one DownShift pulse, PopAck=1 for one cycle; Count=2; head reads 5, entry 1 reads 7.
- Push 8 tokens (1..7,0) -> Full=1 and PushReady=0 after the 8th; a 9th PushValid is not accepted (Err=1 with RF_QUEUE_ERR_EN).
- Count=4, push 6 and pop in the same cycle -> WRF and DownShift together, WriteAddr=4; Count stays 4; token 6 appears at entry 3.
- Count=5, assert Flush one cycle -> Busy=1 for 5 cycles, 5 DownShift pulses, PushValid ignored meanwhile; Count=0, Empty=1; Err cleared.
- Rst pulsed in the 2nd flush cycle -> all outputs return to reset values at once; Count=0; a push on the next cycle writes WriteAddr=0.
